dbg_trace_buffer: RTL and testbench

DBG_TRACE_BUFFER -- requirements
Module: dbg_trace_buffer

---
 rtl/dbg_trace_buffer_pkg.sv | 6 +
 rtl/dbg_trace_buffer_if.sv | 26 ++
 rtl/dbg_trace_buffer_trace_ram.sv | 23 ++
 rtl/dbg_trace_buffer.sv | 114 +++++++++++
 tb/tb_dbg_trace_buffer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dbg_trace_buffer_pkg.sv
// dbg_trace_buffer_pkg: shared state and trigger-mode types for the debug trace buffer and control unit
package dbg_trace_buffer_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} trace_state_t;
  typedef enum logic [1:0] {TRIG_MATCH, TRIG_MISMATCH, TRIG_CHANGE, TRIG_EXT} trig_mode_t;
  typedef enum logic [1:0] {CU_IDLE, CU_FETCH, CU_EXEC, CU_WB} cu_state_t;
endpackage

// File: rtl/dbg_trace_buffer_if.sv
// dbg_trace_buffer_if: capture, trigger and readout signals; master drives stimulus/reads, slave is the buffer
interface dbg_trace_buffer_if import dbg_trace_buffer_pkg::*; #(parameter int TRACE_W = 32, parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH) + 1;
  logic enable;
  logic sample_valid;
  logic [TRACE_W-1:0] sample_data;
  trig_mode_t trig_mode;
  logic [TRACE_W-1:0] trig_mask;
  logic [TRACE_W-1:0] trig_value;
  logic ext_trig;
  logic rd_req;
  logic rd_valid;
  logic [TRACE_W-1:0] rd_data;
  logic rd_last;
  trace_state_t state;
  logic [CW-1:0] count;
  logic [CW-1:0] trig_pos;
  modport master (
    output enable, sample_valid, sample_data, trig_mode, trig_mask, trig_value, ext_trig, rd_req,
    input rd_valid, rd_data, rd_last, state, count, trig_pos
  );
  modport slave (
    input enable, sample_valid, sample_data, trig_mode, trig_mask, trig_value, ext_trig, rd_req,
    output rd_valid, rd_data, rd_last, state, count, trig_pos
  );
endinterface

// File: rtl/dbg_trace_buffer_trace_ram.sv
// trace_ram: DEPTH x TRACE_W storage; ports clk, rst (sync active-low, clears read register only), one write port, one registered read port
module trace_ram #(
  parameter int TRACE_W = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [TRACE_W-1:0]       wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [TRACE_W-1:0]       rdata_o
);
  logic [TRACE_W-1:0] mem [DEPTH];
  logic [TRACE_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (!rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/dbg_trace_buffer.sv
// dbg_trace_buffer: triggered trace capture with post-trigger window and in-order readout; ports clk, rst (sync active-low), bus (slave side of dbg_trace_buffer_if)
module dbg_trace_buffer import dbg_trace_buffer_pkg::*; #(
  parameter int TRACE_W = 32,
  parameter int DEPTH = 16,
  parameter int POST_TRIG = 8
) (
  input logic clk,
  input logic rst,
  dbg_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] TP_CAP = CW'(DEPTH - POST_TRIG);
  localparam logic [CW-1:0] ONE = CW'(1);
  trace_state_t state_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nx;
  logic [CW-1:0] count_q, cnt_nx, trig_pos_q, post_q, rd_cnt_q;
  logic [TRACE_W-1:0] prev_q, masked;
  logic hist_q, rd_valid_q, rd_last_q;
  logic capturing, wr_en, abort, hit, trig, rd_en, rd_fin;
  always_comb begin
    masked = bus.sample_data & bus.trig_mask;
    capturing = state_q == ARMED || state_q == POST;
    abort = capturing && !bus.enable;
    wr_en = capturing && bus.enable && bus.sample_valid;
    wr_ptr_nx = wr_ptr_q + AW'(1);
    cnt_nx = count_q == FULL ? count_q : count_q + ONE;
    hit = bus.trig_mode == TRIG_MATCH    ? masked == (bus.trig_value & bus.trig_mask) :
          bus.trig_mode == TRIG_MISMATCH ? masked != (bus.trig_value & bus.trig_mask) :
          bus.trig_mode == TRIG_CHANGE   ? hist_q && masked != prev_q :
                                           bus.ext_trig;
    trig = wr_en && state_q == ARMED && hit;
    rd_en = state_q == DONE && bus.rd_req && rd_cnt_q != count_q;
    rd_fin = rd_en && rd_cnt_q + ONE == count_q;
  end
  // Trigger index in read order: samples beyond DEPTH-POST_TRIG would be pushed out by the post window, so clamp there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      trig_pos_q <= '0;
      post_q <= '0;
      rd_cnt_q <= '0;
      prev_q <= '0;
      hist_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_last_q <= rd_fin;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_nx;
        count_q <= cnt_nx;
        prev_q <= masked;
        hist_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (bus.enable) begin
          state_q <= ARMED;
          wr_ptr_q <= '0;
          count_q <= '0;
          hist_q <= 1'b0;
        end
        ARMED: if (abort) begin
          state_q <= IDLE;
          count_q <= '0;
        end else if (trig) begin
          trig_pos_q <= (cnt_nx > TP_CAP ? TP_CAP : cnt_nx) - ONE;
          post_q <= CW'(POST_TRIG);
          if (POST_TRIG == 0) begin
            state_q <= DONE;
            rd_ptr_q <= wr_ptr_nx - cnt_nx[AW-1:0];
            rd_cnt_q <= '0;
          end else state_q <= POST;
        end
        POST: if (abort) begin
          state_q <= IDLE;
          count_q <= '0;
        end else if (wr_en) begin
          post_q <= post_q - ONE;
          if (post_q == ONE) begin
            state_q <= DONE;
            rd_ptr_q <= wr_ptr_nx - cnt_nx[AW-1:0];
            rd_cnt_q <= '0;
          end
        end
        DONE: if (rd_en) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
          rd_cnt_q <= rd_cnt_q + ONE;
          if (rd_fin) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  trace_ram #(.TRACE_W(TRACE_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .rst(rst),
    .we_i(wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.sample_data),
    .re_i(rd_en),
    .raddr_i(rd_ptr_q),
    .rdata_o(bus.rd_data)
  );
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last = rd_last_q;
  assign bus.state = state_q;
  assign bus.count = count_q;
  assign bus.trig_pos = trig_pos_q;
endmodule

// File: tb/tb_dbg_trace_buffer.sv
// tb_dbg_trace_buffer: directed table and sequence checks of dbg_trace_buffer at TRACE_W=32, DEPTH=16, POST_TRIG=8
module tb_dbg_trace_buffer;
  import dbg_trace_buffer_pkg::*;
  logic clk, rst;
  int total = 0;
  int bad = 0;
  dbg_trace_buffer_if #(.TRACE_W(32), .DEPTH(16)) bus ();
  dbg_trace_buffer #(.TRACE_W(32), .DEPTH(16), .POST_TRIG(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic en;
    logic vld;
    logic ext;
    logic [31:0] data;
    trig_mode_t mode;
    trace_state_t st;
    logic [4:0] cnt;
  } vec_t;
  vec_t vecs[$];
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 0;
    bus.enable = 0;
    bus.sample_valid = 0;
    bus.sample_data = 0;
    bus.ext_trig = 0;
    bus.rd_req = 0;
    tick();
    tick();
    rst = 1;
  endtask
  task automatic arm(input trig_mode_t m, input logic [31:0] mask, input logic [31:0] val);
    bus.trig_mode = m;
    bus.trig_mask = mask;
    bus.trig_value = val;
    bus.enable = 1;
    tick();
  endtask
  task automatic run_match(input logic [31:0] val, input int exp_done, input int exp_cnt, input int exp_tp, input int first);
    int done_at;
    do_reset();
    arm(TRIG_MATCH, 32'hFFFF_FFFF, val);
    done_at = -1;
    for (int i = 0; i < 40; i++) begin
      bus.sample_valid = 1;
      bus.sample_data = i;
      tick();
      if (done_at < 0 && bus.state == DONE) done_at = i;
    end
    bus.sample_valid = 0;
    bus.enable = 0;
    chk("done_at", 32'(done_at), 32'(exp_done));
    chk("done_state", bus.state, DONE);
    chk("done_count", bus.count, 32'(exp_cnt));
    chk("trig_pos", bus.trig_pos, 32'(exp_tp));
    bus.rd_req = 1;
    for (int k = 0; k < exp_cnt; k++) begin
      tick();
      chk("rd_valid", bus.rd_valid, 1);
      chk("rd_data", bus.rd_data, 32'(first + k));
      chk("rd_last", bus.rd_last, k == exp_cnt - 1);
    end
    tick();
    chk("rd_after_last", bus.rd_valid, 0);
    chk("idle_after_read", bus.state, IDLE);
    bus.rd_req = 0;
  endtask
  initial begin
    bus.trig_mode = TRIG_MATCH;
    bus.trig_mask = 0;
    bus.trig_value = 0;
    do_reset();
    chk("rst_state", bus.state, IDLE);
    chk("rst_count", bus.count, 0);
    chk("rst_trig_pos", bus.trig_pos, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    run_match(32'd20, 28, 16, 7, 13);
    run_match(32'd2, 10, 11, 2, 0);
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h55,  TRIG_CHANGE,   IDLE,  5'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h100, TRIG_CHANGE,   ARMED, 5'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h100, TRIG_CHANGE,   ARMED, 5'd1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h100, TRIG_CHANGE,   ARMED, 5'd2});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h100, TRIG_CHANGE,   ARMED, 5'd3});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h100, TRIG_CHANGE,   ARMED, 5'd4});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h100, TRIG_CHANGE,   ARMED, 5'd5});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h101, TRIG_CHANGE,   POST,  5'd6});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   TRIG_CHANGE,   IDLE,  5'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h0,   TRIG_EXT,      ARMED, 5'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h0,   TRIG_EXT,      ARMED, 5'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h5,   TRIG_EXT,      ARMED, 5'd1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h6,   TRIG_EXT,      POST,  5'd2});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   TRIG_EXT,      IDLE,  5'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   TRIG_MATCH,    ARMED, 5'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h101, TRIG_MATCH,    ARMED, 5'd1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h230, TRIG_MATCH,    POST,  5'd2});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   TRIG_MATCH,    IDLE,  5'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   TRIG_MISMATCH, ARMED, 5'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h120, TRIG_MISMATCH, ARMED, 5'd1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h7,   TRIG_MISMATCH, POST,  5'd2});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   TRIG_MISMATCH, IDLE,  5'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   TRIG_CHANGE,   ARMED, 5'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h3,   TRIG_CHANGE,   ARMED, 5'd1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h13,  TRIG_CHANGE,   ARMED, 5'd2});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h4,   TRIG_CHANGE,   POST,  5'd3});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   TRIG_CHANGE,   IDLE,  5'd0});
    do_reset();
    bus.trig_mask = 32'hF;
    bus.trig_value = 0;
    foreach (vecs[i]) begin
      bus.enable = vecs[i].en;
      bus.sample_valid = vecs[i].vld;
      bus.ext_trig = vecs[i].ext;
      bus.sample_data = vecs[i].data;
      bus.trig_mode = vecs[i].mode;
      tick();
      chk($sformatf("vec%0d_state", i), bus.state, vecs[i].st);
      chk($sformatf("vec%0d_count", i), bus.count, vecs[i].cnt);
    end
    bus.ext_trig = 0;
    do_reset();
    arm(TRIG_MATCH, 32'hFFFF_FFFF, 32'd99);
    for (int i = 0; i < 2; i++) begin
      bus.sample_valid = 1;
      bus.sample_data = i;
      tick();
    end
    chk("abort_pre_count", bus.count, 2);
    bus.enable = 0;
    bus.sample_data = 99;
    tick();
    chk("abort_state", bus.state, IDLE);
    chk("abort_count", bus.count, 0);
    bus.sample_valid = 0;
    bus.rd_req = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort_rd_valid", bus.rd_valid, 0);
    end
    bus.rd_req = 0;
    do_reset();
    arm(TRIG_MATCH, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 6; i++) begin
      bus.sample_valid = 1;
      bus.sample_data = i;
      tick();
    end
    chk("midpost_state", bus.state, POST);
    chk("midpost_trig_pos", bus.trig_pos, 2);
    rst = 0;
    tick();
    chk("rstpost_state", bus.state, IDLE);
    chk("rstpost_count", bus.count, 0);
    chk("rstpost_trig_pos", bus.trig_pos, 0);
    chk("rstpost_rd_valid", bus.rd_valid, 0);
    chk("rstpost_rd_data", bus.rd_data, 0);
    rst = 1;
    bus.enable = 0;
    bus.sample_valid = 0;
    bus.rd_req = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rstpost_rd_req", bus.rd_valid, 0);
      chk("rstpost_idle", bus.state, IDLE);
    end
    bus.rd_req = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
